bb_slave_port: RTL and testbench
================================

Name: bb_slave_port

Overview:
- Bit-serial bus slave port. It is the receive-side counterpart of the bus master port and sits between the bus interconnect and one memory-mapped slave (BRAM/register file).
- Deserialises the 16-bit address and the write data sent MSB-first by the master, checks the device-select bits against its own ID, and drives ack back to the master.
- Issues single-byte memory reads and writes, then serialises read data back to the master MSB-first.
- When a read is slow, optionally releases the bus with split.

Parameters:
DEVICE_ID, 4'h1, value the top DEV_BITS address bits must match
DEV_BITS, 4, number of device-select bits at the head of the address
MEM_ADDR_W, 12, memory address width; equals 16-DEV_BITS
SPLIT_EN, 1, 1 = assert split while waiting on a memory read
SPLIT_THRESH, 4, cycles waited on mem_rvalid before split asserts

Ports:
clk  in  1  system clock
rstn  in  1  reset
mode  in  1  transaction type from master; 1 = write, 0 = read
wr_bus  in  1  serial address/write-data bit from master
master_valid  in  1  wr_bus holds a valid bit
slave_ready  out  1  slave accepts a wr_bus bit this cycle
rd_bus  out  1  serial read-data bit to master
slave_valid  out  1  rd_bus holds a valid bit
master_ready  in  1  master accepts the rd_bus bit this cycle
ack  out  1  device ID matched
split  out  1  slave releases bus pending read data
mem_addr  out  MEM_ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  8  memory read data
mem_rvalid  in  1  mem_rdata valid; single-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: all outputs are 0 except slave_ready = 1. State = IDLE. All counters and shift registers = 0.
- Bit acceptance: a wr_bus bit is accepted on a clk edge where master_valid & slave_ready are both high. Shift register update: sr <= {sr[14:0], wr_bus}.
- Bit delivery: a rd_bus bit is consumed on a clk edge where slave_valid & master_ready are both high.
- States: IDLE, DEV, ADDR, WR_DATA, MEM_WR, MEM_RD, RD_DATA, IGNORE.
- IDLE:
  - slave_ready = 1.
  - First accepted bit: store it, set bit count to 1, go to DEV.
  - mode is sampled and held on this same edge.
- DEV (slave_ready = 1):
  - Accept bits until DEV_BITS bits are held.
  - On the edge that accepts the DEV_BITS-th bit:
    - if the ID matches DEVICE_ID, register ack = 1 and go to ADDR;
    - otherwise ack stays 0 and go to IGNORE.
- ack behaviour: once set, ack stays 1 until the transaction returns to IDLE. The master samples ack no earlier than the cycle after the DEV_BITS-th bit.
- IGNORE:
  - slave_ready = 0.
  - Return to IDLE on the first cycle master_valid = 0.
- ADDR (slave_ready = 1):
  - Accept the remaining MEM_ADDR_W bits.
  - On the edge accepting the last address bit, latch mem_addr.
  - Then go to WR_DATA if mode = 1, else MEM_RD.
- WR_DATA (slave_ready = 1):
  - Accept 8 bits into mem_wdata, MSB first.
  - On the 8th accepted bit go to MEM_WR.
- MEM_WR:
  - mem_we = 1 for exactly one cycle, then IDLE.
  - slave_ready = 0 in this state.
- MEM_RD:
  - mem_re = 1 on the first cycle only.
  - Wait for mem_rvalid, then latch mem_rdata into the output shift register and go to RD_DATA.
  - If SPLIT_EN = 1 and the wait counter reaches SPLIT_THRESH, split = 1 until the cycle mem_rvalid is seen. split drops on the edge that latches the data.
  - If mem_rvalid arrives on the same cycle as mem_re, no wait occurs and split never asserts.
- RD_DATA:
  - slave_valid = 1 and rd_bus = shift register bit 7.
  - On each consumed bit, shift left and increment the count.
  - After the 8th consumed bit, go to IDLE with slave_valid = 0.
- master_valid stalls: in DEV, ADDR or WR_DATA, master_valid may drop for any number of cycles. The slave holds its state and count with no timeout.
- Reset mid-transaction: immediate return to IDLE. No memory strobe is issued, and a strobe already in progress is cut.
- Strobes: mem_we and mem_re are never high together and never high outside MEM_WR/MEM_RD.

Test Plan:
1. Write 0x1ABC, data 0x5A, DEVICE_ID = 1, mode = 1, master_valid held high -> ack = 1 from the cycle after bit 4; exactly one mem_we pulse with mem_addr = 0xABC, mem_wdata = 0x5A; back in IDLE one cycle later.
2. Read 0x1123, memory returns 0xC3 one cycle after mem_re, master_ready held high -> single mem_re with mem_addr = 0x123; rd_bus sequence 1,1,0,0,0,0,1,1 on 8 consecutive slave_valid cycles; split stays 0.
3. Read, mem_rvalid delayed 10 cycles, SPLIT_THRESH = 4 -> split rises 4 cycles after mem_re and falls on the data-latch edge; rd_bus then carries the data correctly.
4. Address 0x2ABC to DEVICE_ID = 1 -> ack stays 0, no mem strobes, IGNORE until master_valid = 0, then IDLE; a following valid write to 0x1000 succeeds.
5. Write with master_valid toggled 1-0-1 per bit and master_ready randomly low during a read -> same memory address, data and rd_bus bit order as the unstalled case.
6. Assert rstn = 0 mid-ADDR, release, then send a full write -> outputs at reset values during reset; no strobe for the aborted transaction; the new write completes normally.

Source files
------------

// File: rtl/bb_slave_port.sv
// Bit-serial bus slave port: deserialises a device/address/write-data stream from
// the master, issues single-byte memory accesses and serialises read data back MSB-first.
module bb_slave_port #(
  parameter int                  DEV_BITS     = 4,
  parameter logic [DEV_BITS-1:0] DEVICE_ID    = 4'h1,
  parameter int                  MEM_ADDR_W   = 12,
  parameter int                  SPLIT_EN     = 1,
  parameter int                  SPLIT_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  output logic                  rd_bus,
  output logic                  slave_valid,
  input  logic                  master_ready,
  output logic                  ack,
  output logic                  split,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_rvalid
);

  typedef enum logic [2:0] {
    IDLE, DEV, ADDR, WR_DATA, MEM_WR, MEM_RD, RD_DATA, IGNORE
  } state_t;

  state_t                  state_reg, state_next;
  logic [MEM_ADDR_W-2:0]   sr_reg, sr_next;
  logic [MEM_ADDR_W-1:0]   sr_shift;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    mode_reg, mode_next;
  logic                    ack_reg, ack_next;
  logic [MEM_ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]              wdata_reg, wdata_next;
  logic [7:0]              rd_sr_reg, rd_sr_next;
  logic [7:0]              wait_reg, wait_next;
  logic                    accept, consume;

  // Only the low MEM_ADDR_W bits of the 16-bit stream are ever needed: the
  // device bits are checked as they arrive and are shifted out by the address.
  assign sr_shift = {sr_reg, wr_bus};

  assign slave_ready = (state_reg == IDLE) || (state_reg == DEV) ||
                       (state_reg == ADDR) || (state_reg == WR_DATA);
  assign slave_valid = (state_reg == RD_DATA);
  assign rd_bus      = (state_reg == RD_DATA) && rd_sr_reg[7];
  assign mem_we      = (state_reg == MEM_WR);
  assign mem_re      = (state_reg == MEM_RD) && (wait_reg == 8'd0);
  assign split       = (SPLIT_EN != 0) && (state_reg == MEM_RD) &&
                       (wait_reg >= 8'(SPLIT_THRESH));
  assign ack         = ack_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign accept      = master_valid && slave_ready;
  assign consume     = slave_valid && master_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_sr_reg <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      ack_reg   <= ack_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rd_sr_reg <= rd_sr_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    ack_next   = ack_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rd_sr_next = rd_sr_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        ack_next = 1'b0;
        if (accept) begin
          sr_next    = sr_shift[MEM_ADDR_W-2:0];
          cnt_next   = 4'd1;
          mode_next  = mode;
          state_next = DEV;
        end
      end
      DEV: begin
        if (accept) begin
          sr_next  = sr_shift[MEM_ADDR_W-2:0];
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'(DEV_BITS - 1)) begin
            if (sr_shift[DEV_BITS-1:0] == DEVICE_ID) begin
              ack_next   = 1'b1;
              state_next = ADDR;
            end else begin
              state_next = IGNORE;
            end
          end
        end
      end
      ADDR: begin
        if (accept) begin
          sr_next  = sr_shift[MEM_ADDR_W-2:0];
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            addr_next  = sr_shift;
            cnt_next   = 4'd0;
            wait_next  = 8'd0;
            state_next = mode_reg ? WR_DATA : MEM_RD;
          end
        end
      end
      WR_DATA: begin
        if (accept) begin
          wdata_next = {wdata_reg[6:0], wr_bus};
          cnt_next   = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next   = 4'd0;
            state_next = MEM_WR;
          end
        end
      end
      MEM_WR: begin
        ack_next   = 1'b0;
        state_next = IDLE;
      end
      MEM_RD: begin
        if (mem_rvalid) begin
          rd_sr_next = mem_rdata;
          wait_next  = 8'd0;
          state_next = RD_DATA;
        end else if (wait_reg != 8'hFF) begin
          // Saturate so mem_re can never re-fire on a very long wait.
          wait_next = wait_reg + 8'd1;
        end
      end
      RD_DATA: begin
        if (consume) begin
          rd_sr_next = {rd_sr_reg[6:0], 1'b0};
          cnt_next   = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            cnt_next   = 4'd0;
            ack_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      IGNORE: begin
        if (!master_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bb_slave_port.sv
// Directed self-checking bench for bb_slave_port: writes, reads with and without
// split, device mismatch, stalled transfers and reset mid-transaction.
module tb_bb_slave_port;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mode = 1'b0;
  logic        wr_bus = 1'b0;
  logic        master_valid = 1'b0;
  logic        master_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        slave_ready, rd_bus, slave_valid, ack, split, mem_we, mem_re;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  int tests_run = 0;
  int tests_failed = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  logic rd_q[$];

  bb_slave_port dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid), .master_ready(master_ready),
    .ack(ack), .split(split), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Bus/strobe observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    if (slave_valid && master_ready) rd_q.push_back(rd_bus);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    bit rdy;
    bit done;
    int n;
    if (stall) begin
      master_valid = 1'b0;
      @(posedge clk); #1;
    end
    master_valid = 1'b1;
    wr_bus = b;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      rdy = slave_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
      else if (++n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_addr(input logic [15:0] a, input bit stall, input string tag);
    for (int i = 15; i >= 0; i--) begin
      send_bit(a[i], stall);
      if (i == 13) chk({tag, "_ack_pre"}, 32'(ack), 32'd0);
      if (i == 12) chk({tag, "_ack"}, 32'(ack), 32'd1);
    end
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [7:0] d, input bit stall, input string tag);
    int we0;
    we0 = we_cnt;
    mode = 1'b1;
    send_addr(a, stall, tag);
    for (int i = 7; i >= 0; i--) send_bit(d[i], stall);
    master_valid = 1'b0;
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a[11:0]));
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
    chk({tag, "_re_low"}, 32'(mem_re), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(slave_ready), 32'd1);
    chk({tag, "_ack_clr"}, 32'(ack), 32'd0);
    chk({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'd1);
  endtask

  task automatic read_txn(input logic [15:0] a, input logic [7:0] d, input int delay,
                          input bit stall, input bit rand_ready, input string tag);
    int re0, q0, n;
    logic [7:0] got;
    re0 = re_cnt;
    mode = 1'b0;
    send_addr(a, stall, tag);
    master_valid = 1'b0;
    if (delay == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata = d;
    end
    chk({tag, "_re"}, 32'(mem_re), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a[11:0]));
    chk({tag, "_split0"}, 32'(split), 32'd0);
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      if (k == delay) begin
        mem_rvalid = 1'b1;
        mem_rdata = d;
      end
      chk($sformatf("%s_split_k%0d", tag, k), 32'(split), 32'(k >= 4));
      chk($sformatf("%s_re_k%0d", tag, k), 32'(mem_re), 32'd0);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk({tag, "_split_drop"}, 32'(split), 32'd0);
    chk({tag, "_svalid"}, 32'(slave_valid), 32'd1);
    chk({tag, "_re_pulses"}, 32'(re_cnt - re0), 32'd1);
    q0 = rd_q.size();
    n = 0;
    while ((rd_q.size() - q0) < 8 && n < 200) begin
      master_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    master_ready = 1'b0;
    chk({tag, "_rd_timeout"}, 32'(n >= 200), 32'd0);
    got = 8'h00;
    for (int i = 0; i < 8 && (q0 + i) < rd_q.size(); i++) got = {got[6:0], rd_q[q0 + i]};
    chk({tag, "_rdata"}, 32'(got), 32'(d));
    chk({tag, "_svalid_off"}, 32'(slave_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(slave_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(slave_ready), 32'd1);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_split"}, 32'(split), 32'd0);
    chk({tag, "_svalid"}, 32'(slave_valid), 32'd0);
    chk({tag, "_rdbus"}, 32'(rd_bus), 32'd0);
    chk({tag, "_we_re"}, 32'({mem_we, mem_re}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int we0, re0;
    logic [15:0] bad;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    write_txn(16'h1ABC, 8'h5A, 1'b0, "wr1");
    read_txn(16'h1123, 8'hC3, 1, 1'b0, 1'b0, "rd2");
    read_txn(16'h1456, 8'h96, 10, 1'b0, 1'b0, "rd3");
    read_txn(16'h1FFF, 8'h81, 0, 1'b0, 1'b0, "rd_same");

    // Device mismatch: slave must ignore until master_valid drops.
    we0 = we_cnt;
    re0 = re_cnt;
    bad = 16'h2ABC;
    mode = 1'b1;
    for (int i = 15; i >= 12; i--) send_bit(bad[i], 1'b0);
    chk("ign_ack", 32'(ack), 32'd0);
    chk("ign_ready", 32'(slave_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_hold", 32'(slave_ready), 32'd0);
    master_valid = 1'b0;
    @(posedge clk); #1;
    chk("ign_idle", 32'(slave_ready), 32'd1);
    chk("ign_strobes", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);
    write_txn(16'h1000, 8'hA5, 1'b0, "wr4");

    write_txn(16'h1ABC, 8'h5A, 1'b1, "wr5");
    read_txn(16'h1123, 8'hC3, 1, 1'b1, 1'b1, "rd5");

    // Reset in the middle of the address phase.
    we0 = we_cnt;
    re0 = re_cnt;
    mode = 1'b1;
    bad = 16'h1ABC;
    for (int i = 15; i >= 8; i--) send_bit(bad[i], 1'b0);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst6");
    repeat (3) @(posedge clk);
    master_valid = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst6_strobes", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);
    write_txn(16'h1DEF, 8'h3C, 1'b0, "wr6");

    chk("strobe_overlap", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
